// File: rtl/x25519_ladder_sequencer.sv
// Montgomery ladder sequencer for one X25519 scalar multiplication.
// Issues 255 iterations to a shared main-loop datapath and returns the projective result (X:Z).
module x25519_ladder_sequencer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] scalar,
    input  logic [255:0] u_in,
    output logic         busy,
    output logic         done,
    output logic [511:0] xz_out,
    output logic         err_spurious,
    output logic         iter_en,
    output logic         iter_b,
    output logic [511:0] iter_xzm,
    output logic [511:0] iter_xzm1,
    output logic [263:0] iter_work,
    input  logic         iter_valid,
    input  logic [511:0] iter_xzm_next,
    input  logic [511:0] iter_xzm1_next
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t       state;
    logic [255:0] e_q;
    logic [255:0] u_q;
    logic [7:0]   pos;
    logic [1:0]   rst_sync;
    logic         rst_core_n;

    // Reset asserts asynchronously but releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_core_n = rst_sync[1];
    assign iter_work  = {8'h00, u_q};

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state        <= S_IDLE;
            e_q          <= '0;
            u_q          <= '0;
            pos          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            xz_out       <= '0;
            err_spurious <= 1'b0;
            iter_en      <= 1'b0;
            iter_b       <= 1'b0;
            iter_xzm     <= '0;
            iter_xzm1    <= '0;
        end else begin
            done    <= 1'b0;
            iter_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        e_q          <= {2'b01, scalar[253:3], 3'b000};
                        u_q          <= {1'b0, u_in[254:0]};
                        err_spurious <= 1'b0;
                        busy         <= 1'b1;
                        state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    iter_xzm  <= {256'h0, 256'h1};
                    iter_xzm1 <= {256'h1, u_q};
                    pos       <= 8'd254;
                    iter_b    <= e_q[254];
                    iter_en   <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (iter_valid) begin
                        iter_xzm  <= iter_xzm_next;
                        iter_xzm1 <= iter_xzm1_next;
                        if (pos == 8'd0) begin
                            // Result is published on entry to DONE so done and xz_out align.
                            xz_out <= iter_xzm_next;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            pos     <= pos - 8'd1;
                            iter_b  <= e_q[pos - 8'd1];
                            iter_en <= 1'b1;
                            state   <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            if (iter_valid && state != S_WAIT) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_x25519_ladder_sequencer.sv
// Scoreboard bench for x25519_ladder_sequencer: iteration stub (identity or real ladder step)
// plus a done-triggered monitor comparing xz_out (or its affine value) against queued expectations.
module tb_x25519_ladder_sequencer;

    localparam logic [255:0] P     = 256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
    localparam logic [255:0] K_RAW = 256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4;
    localparam logic [255:0] U_RAW = 256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c;
    localparam logic [255:0] R_RAW = 256'hc3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] scalar;
    logic [255:0] u_in;
    logic         busy, done, err_spurious, iter_en, iter_b;
    logic [511:0] xz_out, iter_xzm, iter_xzm1;
    logic [263:0] iter_work;
    logic         iter_valid;
    logic [511:0] iter_xzm_next, iter_xzm1_next;

    logic         stub_valid = 1'b0;
    logic [511:0] stub_m     = '0;
    logic [511:0] stub_m1    = '0;
    logic         spur_valid = 1'b0;
    logic [511:0] spur_m     = {16{32'hdeadbeef}};
    int           stub_mode  = 0;
    int           pulses     = 0;
    logic         bit_log [0:4095];
    int           cyc        = 0;
    int           done_count = 0;
    int           checks     = 0;
    int           errors     = 0;

    typedef struct {
        int           mode;
        logic [511:0] exp;
        string        name;
    } exp_t;
    exp_t sb[$];

    assign iter_valid     = stub_valid | spur_valid;
    assign iter_xzm_next  = spur_valid ? spur_m : stub_m;
    assign iter_xzm1_next = spur_valid ? ~spur_m : stub_m1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    x25519_ladder_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .scalar        (scalar),
        .u_in          (u_in),
        .busy          (busy),
        .done          (done),
        .xz_out        (xz_out),
        .err_spurious  (err_spurious),
        .iter_en       (iter_en),
        .iter_b        (iter_b),
        .iter_xzm      (iter_xzm),
        .iter_xzm1     (iter_xzm1),
        .iter_work     (iter_work),
        .iter_valid    (iter_valid),
        .iter_xzm_next (iter_xzm_next),
        .iter_xzm1_next(iter_xzm1_next)
    );

    function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = ({256'h0, a} + {256'h0, b}) % {256'h0, P};
        return t[255:0];
    endfunction

    function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = ({256'h0, a} % {256'h0, P}) + {256'h0, P} - ({256'h0, b} % {256'h0, P});
        t = t % {256'h0, P};
        return t[255:0];
    endfunction

    function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] t;
        t = ({256'h0, a} * {256'h0, b}) % {256'h0, P};
        return t[255:0];
    endfunction

    function automatic logic [255:0] finv(input logic [255:0] z);
        logic [255:0] r, base, ex;
        r = 256'h1; base = z; ex = P - 256'd2;
        for (int i = 0; i < 256; i++) begin
            if (ex[i]) r = fmul(r, base);
            base = fmul(base, base);
        end
        return r;
    endfunction

    function automatic logic [255:0] bswap(input logic [255:0] v);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[i*8 +: 8] = v[(31-i)*8 +: 8];
        return r;
    endfunction

    // Reference main-loop iteration: cswap, double-and-add, cswap back.
    function automatic void ladder_step(input logic b, input logic [511:0] m, input logic [511:0] m1,
                                        input logic [255:0] x1, output logic [511:0] nm, output logic [511:0] nm1);
        logic [255:0] x2, z2, x3, z3, a, aa, bq, bb, e, c, d, da, cb, t;
        if (b) begin
            x2 = m1[255:0]; z2 = m1[511:256]; x3 = m[255:0]; z3 = m[511:256];
        end else begin
            x2 = m[255:0]; z2 = m[511:256]; x3 = m1[255:0]; z3 = m1[511:256];
        end
        a  = fadd(x2, z2); aa = fmul(a, a);
        bq = fsub(x2, z2); bb = fmul(bq, bq);
        e  = fsub(aa, bb);
        c  = fadd(x3, z3); d = fsub(x3, z3);
        da = fmul(d, a);   cb = fmul(c, bq);
        t  = fadd(da, cb); x3 = fmul(t, t);
        t  = fsub(da, cb); z3 = fmul(x1, fmul(t, t));
        x2 = fmul(aa, bb);
        z2 = fmul(e, fadd(aa, fmul(256'd121665, e)));
        if (b) begin
            nm = {z3, x3}; nm1 = {z2, x2};
        end else begin
            nm = {z2, x2}; nm1 = {z3, x3};
        end
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Iteration stub: 3-cycle latency from iter_en to iter_valid.
    initial begin
        forever begin
            @(negedge clk);
            while (iter_en) begin
                if (pulses < 4096) bit_log[pulses] = iter_b;
                pulses++;
                if (stub_mode == 1) begin
                    ladder_step(iter_b, iter_xzm, iter_xzm1, iter_work[255:0], stub_m, stub_m1);
                end else begin
                    stub_m  = iter_xzm;
                    stub_m1 = iter_xzm1;
                end
                repeat (3) @(negedge clk);
                stub_valid = 1'b1;
                @(negedge clk);
                stub_valid = 1'b0;
            end
        end
    end

    // Monitor: every done pops one expectation.
    initial begin
        exp_t         e;
        logic [255:0] aff;
        forever begin
            @(negedge clk);
            if (done) begin
                done_count++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", {511'h0, done}, 512'h0);
                end else begin
                    e = sb.pop_front();
                    if (e.mode == 0) begin
                        chk(e.name, xz_out, e.exp);
                    end else begin
                        aff = fmul(xz_out[255:0], finv(xz_out[511:256]));
                        chk(e.name, {256'h0, aff}, e.exp);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int mode, input logic [511:0] exp, input string name);
        exp_t e;
        e.mode = mode; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    // Returns at the negedge of the start-accept cycle + 1.
    task automatic do_start(input logic [255:0] k, input logic [255:0] u, output int s_cyc);
        scalar = k; u_in = u; start = 1'b1;
        s_cyc  = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {511'h0, done}, 512'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},    {511'h0, busy},         512'h0);
        chk({tag, "_done"},    {511'h0, done},         512'h0);
        chk({tag, "_iter_en"}, {511'h0, iter_en},      512'h0);
        chk({tag, "_iter_b"},  {511'h0, iter_b},       512'h0);
        chk({tag, "_xz_out"},  xz_out,                 512'h0);
        chk({tag, "_err"},     {511'h0, err_spurious}, 512'h0);
        chk({tag, "_xzm"},     iter_xzm,               512'h0);
        chk({tag, "_work"},    {248'h0, iter_work},    512'h0);
    endtask

    localparam logic [511:0] XZ_ID = {256'h0, 256'h1};

    initial begin
        int           s_cyc, base, base2, dc0, n, ones;
        logic [255:0] all1, umask;
        logic [511:0] xz_prev, xzm_prev, xzm1_prev;
        all1  = '1;
        umask = {1'b0, {255{1'b1}}};
        rst_n = 1'b0; start = 1'b0; scalar = '0; u_in = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Bit order, pulse count and latency with all-ones scalar.
        stub_mode = 0;
        base = pulses;
        push_exp(0, XZ_ID, "allones_xz_out");
        do_start(all1, 256'h9, s_cyc);
        chk("busy_at_start_plus_1", {511'h0, busy}, 512'h1);
        @(negedge clk);
        chk("iter_en_at_start_plus_2", {511'h0, iter_en}, 512'h1);
        wait_done(1200, "allones_done_reached");
        chk("allones_latency", 512'(cyc - s_cyc), 512'd1022);
        chk("allones_pulses", 512'(pulses - base), 512'd255);
        chk("busy_low_at_done", {511'h0, busy}, 512'h0);
        for (int i = 0; i < 255; i++) begin
            chk($sformatf("allones_bit_pos%0d", 254 - i), {511'h0, bit_log[base + i]},
                (254 - i) >= 3 ? 512'h1 : 512'h0);
        end
        repeat (2) @(negedge clk);

        // Initial operands and masking with scalar=0, u=all-ones.
        base = pulses;
        push_exp(0, XZ_ID, "zero_scalar_xz_out");
        do_start(256'h0, all1, s_cyc);
        @(negedge clk);
        chk("first_iter_xzm",  iter_xzm,  XZ_ID);
        chk("first_iter_xzm1", iter_xzm1, {256'h1, umask});
        chk("first_iter_work", {248'h0, iter_work}, {248'h0, 8'h00, umask});
        chk("first_iter_b",    {511'h0, iter_b}, 512'h1);
        wait_done(1200, "zero_scalar_done_reached");
        ones = 0;
        for (int i = 0; i < 255; i++) ones += int'(bit_log[base + i]);
        chk("zero_scalar_ones_count", 512'(ones), 512'd1);
        repeat (2) @(negedge clk);

        // RFC 7748 vector with the real ladder step.
        stub_mode = 1;
        push_exp(1, {256'h0, bswap(R_RAW)}, "rfc7748_affine_u");
        do_start(bswap(K_RAW), bswap(U_RAW), s_cyc);
        wait_done(1200, "rfc_done_reached");
        chk("rfc_err_spurious", {511'h0, err_spurious}, 512'h0);
        repeat (2) @(negedge clk);

        // start held high through an operation and into the cycle after done.
        stub_mode = 0;
        dc0 = done_count;
        base = pulses;
        push_exp(0, XZ_ID, "interlock_op1_xz_out");
        push_exp(0, XZ_ID, "interlock_op2_xz_out");
        scalar = all1; u_in = 256'h5; start = 1'b1;
        s_cyc = cyc;
        wait_done(1200, "interlock_op1_done_reached");
        chk("interlock_op1_latency", 512'(cyc - s_cyc), 512'd1022);
        chk("interlock_op1_pulses", 512'(pulses - base), 512'd255);
        @(negedge clk);
        @(negedge clk);
        chk("interlock_restart_busy", {511'h0, busy}, 512'h1);
        start = 1'b0;
        base2 = pulses;
        wait_done(1200, "interlock_op2_done_reached");
        chk("interlock_op2_pulses", 512'(pulses - base2), 512'd255);
        @(negedge clk);
        chk("interlock_done_count", 512'(done_count - dc0), 512'd2);
        repeat (2) @(negedge clk);

        // Spurious valid in IDLE.
        xz_prev = xz_out; xzm_prev = iter_xzm; xzm1_prev = iter_xzm1;
        spur_valid = 1'b1;
        @(negedge clk);
        spur_valid = 1'b0;
        @(negedge clk);
        chk("spur_idle_err",   {511'h0, err_spurious}, 512'h1);
        chk("spur_idle_xz",    xz_out,    xz_prev);
        chk("spur_idle_xzm",   iter_xzm,  xzm_prev);
        chk("spur_idle_xzm1",  iter_xzm1, xzm1_prev);

        // Start clears the flag; spurious valid in ISSUE sets it and is ignored.
        push_exp(0, XZ_ID, "spur_issue_xz_out");
        do_start(all1, 256'h9, s_cyc);
        chk("err_cleared_on_start", {511'h0, err_spurious}, 512'h0);
        @(negedge clk);
        spur_valid = 1'b1;
        @(negedge clk);
        spur_valid = 1'b0;
        chk("spur_issue_err", {511'h0, err_spurious}, 512'h1);
        chk("spur_issue_xzm", iter_xzm, XZ_ID);
        wait_done(1200, "spur_issue_done_reached");
        chk("spur_err_sticky", {511'h0, err_spurious}, 512'h1);
        repeat (2) @(negedge clk);

        // Reset at iteration 100 aborts without done.
        dc0 = done_count;
        base = pulses;
        do_start(all1, 256'h9, s_cyc);
        n = 0;
        while ((pulses - base) < 100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_iteration_100", 512'(pulses - base), 512'd100);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_done_after_abort", 512'(done_count - dc0), 512'd0);
        base = pulses;
        push_exp(0, XZ_ID, "post_reset_xz_out");
        do_start(all1, 256'h9, s_cyc);
        wait_done(1200, "post_reset_done_reached");
        chk("post_reset_pulses", 512'(pulses - base), 512'd255);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 512'(sb.size()), 512'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
